// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin share of the Debug Module's single DMI request/response channel between two requesters
// Ports: clk_i/rst_i (sync, active-high); s_req_* per-port request channels (port 0 JTAG DTM, port 1 memory-mapped);
//   s_resp_* per-port response valid/ready with shared data/op; m_req_*/m_resp_* channel to riscv_dm; busy_o when not IDLE.
// Optional: define DMI_ARB_TIMEOUT_EN to enable the response timeout and stale-response discard.
package riscv_dm_pkg;
  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH = 2;
endpackage

module dmi_arbiter #(
  parameter int ADDR_WIDTH = riscv_dm_pkg::DMI_ADDR_WIDTH,
  parameter int DATA_WIDTH = riscv_dm_pkg::DMI_DATA_WIDTH,
  parameter int OP_WIDTH = riscv_dm_pkg::DMI_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 s_req_valid_i,
  output logic [1:0]                 s_req_ready_o,
  input  logic [1:0][ADDR_WIDTH-1:0] s_req_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] s_req_data_i,
  input  logic [1:0][OP_WIDTH-1:0]   s_req_op_i,
  output logic [1:0]                 s_resp_valid_o,
  input  logic [1:0]                 s_resp_ready_i,
  output logic [DATA_WIDTH-1:0]      s_resp_data_o,
  output logic [OP_WIDTH-1:0]        s_resp_op_o,
  output logic                       m_req_valid_o,
  input  logic                       m_req_ready_i,
  output logic [ADDR_WIDTH-1:0]      m_req_addr_o,
  output logic [DATA_WIDTH-1:0]      m_req_data_o,
  output logic [OP_WIDTH-1:0]        m_req_op_o,
  input  logic                       m_resp_valid_i,
  output logic                       m_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]      m_resp_data_i,
  input  logic [OP_WIDTH-1:0]        m_resp_op_i,
  output logic                       busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic last_q, owner_q, stale_q, stale_d, g, grant, expire;
  logic m_req_valid_q, m_resp_ready_q, busy_q;
  logic [1:0] s_resp_valid_q;
  logic [ADDR_WIDTH-1:0] m_req_addr_q;
  logic [DATA_WIDTH-1:0] m_req_data_q, s_resp_data_q;
  logic [OP_WIDTH-1:0] m_req_op_q, s_resp_op_q;

  // A tie goes to the port that did not win last; a lone requester always wins.
  assign g = &s_req_valid_i ? ~last_q : s_req_valid_i[1];
  // Ready only goes to the winner, so a grant is also the request handshake.
  assign grant = state_q == IDLE && |s_req_valid_i && !stale_q && !rst_i;
  assign s_req_ready_o = grant ? (g ? 2'b10 : 2'b01) : 2'b00;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  // Fires on the TIMEOUT_CYCLES-th cycle in WAIT; a response in that same cycle wins.
  assign expire = state_q == WAIT && !m_resp_valid_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // The abandoned DM response is still owed; swallow it before granting again.
  assign stale_d = expire | (stale_q & ~(m_resp_valid_i & m_resp_ready_o));
  always_ff @(posedge clk_i) cnt_q <= (rst_i || state_q != WAIT) ? '0 : cnt_q + CW'(1);
`else
  logic unused_tc;
  assign unused_tc = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
  assign stale_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = grant ? REQ : IDLE;
      REQ:  state_d = m_req_ready_i ? WAIT : REQ;
      WAIT: state_d = (m_resp_valid_i || expire) ? RESP : WAIT;
      RESP: state_d = s_resp_ready_i[owner_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      stale_q <= 1'b0;
      m_req_valid_q <= 1'b0;
      m_resp_ready_q <= 1'b0;
      s_resp_valid_q <= 2'b00;
      busy_q <= 1'b0;
      m_req_addr_q <= '0;
      m_req_data_q <= '0;
      m_req_op_q <= '0;
      s_resp_data_q <= '0;
      s_resp_op_q <= '0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      m_req_valid_q <= state_d == REQ;
      m_resp_ready_q <= state_d == WAIT || stale_d;
      s_resp_valid_q <= state_d == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      busy_q <= state_d != IDLE;
      if (grant) begin
        owner_q <= g;
        last_q <= g;
        m_req_addr_q <= s_req_addr_i[g];
        m_req_data_q <= s_req_data_i[g];
        m_req_op_q <= s_req_op_i[g];
      end
      if (state_q == WAIT && state_d == RESP) begin
        s_resp_data_q <= expire ? '0 : m_resp_data_i;
        s_resp_op_q <= expire ? OP_WIDTH'(2) : m_resp_op_i;
      end
    end
  end

  assign m_req_valid_o = m_req_valid_q;
  assign m_req_addr_o = m_req_addr_q;
  assign m_req_data_o = m_req_data_q;
  assign m_req_op_o = m_req_op_q;
  assign m_resp_ready_o = m_resp_ready_q;
  assign s_resp_valid_o = s_resp_valid_q;
  assign s_resp_data_o = s_resp_data_q;
  assign s_resp_op_o = s_resp_op_q;
  assign busy_o = busy_q;
endmodule
